// File: rtl/seq_detect_param.sv
// Moore serial-pattern detector with a runtime-loadable PAT_LEN-bit pattern,
// selectable overlapping/non-overlapping matching and a saturating match counter.
module seq_detect_param #(
    parameter int                 PAT_LEN     = 3,
    parameter logic [PAT_LEN-1:0] PAT_DEFAULT = '0,
    parameter bit                 OVL_DEFAULT = 1'b1,
    parameter int                 CNT_W       = 8,
    localparam int                FILL_W      = $clog2(PAT_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               din,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [FILL_W-1:0]  fill
);

    localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic               ovl_q, ovl_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [PAT_LEN-1:0] hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               hit;

    always_comb begin
        hist_d     = hist_q;
        fill_d     = fill_q;
        pat_d      = pat_q;
        ovl_d      = ovl_q;
        count_d    = count_q;
        hit        = 1'b0;
        hist_shift = {hist_q[PAT_LEN-2:0], din};
        fill_inc   = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);

        // A config load wipes any partial match and drops a coincident sample.
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_shift;
            // Gating on fill keeps the zeroed history from aliasing an all-zero pattern.
            hit    = (fill_inc == FULL) && (hist_shift == pat_q);
            fill_d = (hit && !ovl_q) ? '0 : fill_inc;
        end

        match_d = hit;

        if (clr_count) begin
            count_d = '0;
        end else if (hit && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PAT_DEFAULT;
            ovl_q   <= OVL_DEFAULT;
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
            count_q <= count_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign fill        = fill_q;

endmodule
